motor_ctrl_regs_axi: RTL and testbench



---
 rtl/motor_ctrl_pkg.sv | 39 +++
 rtl/motor_ctrl_chan_regs.sv | 70 +++++++
 rtl/motor_ctrl_regs_axi.sv | 258 +++++++++++++++++++++++++
 tb/tb_motor_ctrl_regs_axi.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: shared constants for the motor control register bank.
// Address offsets, CTRL bits, AXI responses and FSM state types.
package motor_ctrl_pkg;

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_INFO     = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_RSVD     = 2'd3;

    localparam logic [1:0] OFF_GAIN     = 2'd0;
    localparam logic [1:0] OFF_VEL_SET  = 2'd1;
    localparam logic [1:0] OFF_POS_SNAP = 2'd2;
    localparam logic [1:0] OFF_VEL_SNAP = 2'd3;

    localparam int CTRL_COMMIT   = 0;
    localparam int CTRL_SNAPSHOT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [15:0] INFO_MAGIC = 16'h5056;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/motor_ctrl_chan_regs.sv
// motor_ctrl_chan_regs: shadow, active and snapshot registers of one
// motor channel; shadows go live on commit, feedback latched on snapshot.
module motor_ctrl_chan_regs
    import motor_ctrl_pkg::*;
#(
    parameter logic [15:0] KP_RESET = 16'h0000,
    parameter logic [15:0] KI_RESET = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        gain_we_i,
    input  logic        vel_we_i,
    input  logic        commit_i,
    input  logic        snapshot_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] pos_i,
    input  logic [31:0] vel_i,
    output logic [31:0] gain_sh_o,
    output logic [31:0] vel_sh_o,
    output logic [31:0] pos_snap_o,
    output logic [31:0] vel_snap_o,
    output logic [15:0] kp_o,
    output logic [15:0] ki_o,
    output logic [31:0] vel_o
);

    logic [31:0] gain_sh_q, gain_sh_d;
    logic [31:0] vel_sh_q, vel_sh_d;
    logic [31:0] gain_act_q, vel_act_q;
    logic [31:0] pos_snap_q, vel_snap_q;

    always_comb begin
        gain_sh_d = gain_sh_q;
        vel_sh_d  = vel_sh_q;
        if (gain_we_i) gain_sh_d = apply_strb(gain_sh_q, wdata_i, wstrb_i);
        if (vel_we_i)  vel_sh_d  = apply_strb(vel_sh_q, wdata_i, wstrb_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gain_sh_q  <= {KI_RESET, KP_RESET};
            vel_sh_q   <= '0;
            gain_act_q <= {KI_RESET, KP_RESET};
            vel_act_q  <= '0;
            pos_snap_q <= '0;
            vel_snap_q <= '0;
        end else begin
            gain_sh_q <= gain_sh_d;
            vel_sh_q  <= vel_sh_d;
            if (commit_i) begin
                gain_act_q <= gain_sh_q;
                vel_act_q  <= vel_sh_q;
            end
            if (snapshot_i) begin
                pos_snap_q <= pos_i;
                vel_snap_q <= vel_i;
            end
        end
    end

    assign gain_sh_o  = gain_sh_q;
    assign vel_sh_o   = vel_sh_q;
    assign pos_snap_o = pos_snap_q;
    assign vel_snap_o = vel_snap_q;
    assign kp_o       = gain_act_q[15:0];
    assign ki_o       = gain_act_q[31:16];
    assign vel_o      = vel_act_q;

endmodule

// File: rtl/motor_ctrl_regs_axi.sv
// motor_ctrl_regs_axi: AXI4-Lite register bank for NUM_CH PI velocity
// loops with atomic gain/setpoint commit and coherent feedback snapshot.
module motor_ctrl_regs_axi
    import motor_ctrl_pkg::*;
#(
    parameter int          NUM_CH               = 2,
    parameter int          C_S00_AXI_DATA_WIDTH = 32,
    parameter int          C_S00_AXI_ADDR_WIDTH = 7,
    parameter logic [15:0] KP_RESET             = 16'h0000,
    parameter logic [15:0] KI_RESET             = 16'h0000
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [16*NUM_CH-1:0]              kp_out,
    output logic [16*NUM_CH-1:0]              ki_out,
    output logic [32*NUM_CH-1:0]              desired_vel,
    input  logic [32*NUM_CH-1:0]              actual_pos,
    input  logic [32*NUM_CH-1:0]              actual_vel,
    output logic                              update_strobe
);

    localparam int AW = C_S00_AXI_ADDR_WIDTH;
    localparam int BW = AW - 4;

    wstate_e w_state_q, w_state_d;
    rstate_e r_state_q, r_state_d;
    logic        aw_rdy_q, aw_rdy_d, bvalid_q, bvalid_d;
    logic        ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] commit_cnt_q, snap_cnt_q;
    logic        strobe_q;

    logic wr_hs, rd_hs, wr_ctrl, commit, snapshot;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_data;
    logic [NUM_CH-1:0] gain_sel, vel_sel;

    logic [31:0] gain_sh [NUM_CH];
    logic [31:0] vel_sh [NUM_CH];
    logic [31:0] pos_snap [NUM_CH];
    logic [31:0] vel_snap [NUM_CH];

    logic [BW-1:0] w_blk, r_blk;
    logic [1:0]    w_off, r_off;
    logic          w_glb, w_chan, r_glb, r_chan;

    assign w_blk  = s00_axi_awaddr[AW-1:4];
    assign w_off  = s00_axi_awaddr[3:2];
    assign r_blk  = s00_axi_araddr[AW-1:4];
    assign r_off  = s00_axi_araddr[3:2];
    assign w_glb  = (w_blk == '0);
    assign w_chan = !w_glb && (int'(w_blk) <= NUM_CH);
    assign r_glb  = (r_blk == '0);
    assign r_chan = !r_glb && (int'(r_blk) <= NUM_CH);

    assign wr_hs = aw_rdy_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_hs = ar_rdy_q & s00_axi_arvalid;

    always_comb begin
        wr_ctrl  = 1'b0;
        gain_sel = '0;
        vel_sel  = '0;
        wr_resp  = RESP_SLVERR;
        unique case (1'b1)
            w_glb: begin
                if (w_off == OFF_CTRL) begin
                    wr_ctrl = s00_axi_wstrb[0];
                    wr_resp = RESP_OKAY;
                end
            end
            w_chan: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(w_blk) == c + 1) begin
                        if (w_off == OFF_GAIN) begin
                            gain_sel[c] = 1'b1;
                            wr_resp     = RESP_OKAY;
                        end
                        if (w_off == OFF_VEL_SET) begin
                            vel_sel[c] = 1'b1;
                            wr_resp    = RESP_OKAY;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign commit   = wr_hs & wr_ctrl & s00_axi_wdata[CTRL_COMMIT];
    assign snapshot = wr_hs & wr_ctrl & s00_axi_wdata[CTRL_SNAPSHOT];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        unique case (1'b1)
            r_glb: begin
                if (r_off == OFF_INFO)
                    rd_data = {INFO_MAGIC, 8'h00, 8'(NUM_CH)};
                if (r_off == OFF_STATUS)
                    rd_data = {snap_cnt_q, commit_cnt_q};
            end
            r_chan: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(r_blk) == c + 1) begin
                        case (r_off)
                            OFF_GAIN:     rd_data = gain_sh[c];
                            OFF_VEL_SET:  rd_data = vel_sh[c];
                            OFF_POS_SNAP: rd_data = pos_snap[c];
                            default:      rd_data = vel_snap[c];
                        endcase
                    end
                end
            end
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    // Ready is a registered one-cycle pulse so reset never exposes it.
    always_comb begin
        w_state_d = w_state_q;
        aw_rdy_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                aw_rdy_d = s00_axi_awvalid & s00_axi_wvalid & ~aw_rdy_q;
                if (wr_hs) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_rdy_d  = 1'b0;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                ar_rdy_d = s00_axi_arvalid & ~ar_rdy_q;
                if (rd_hs) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rresp_d   = rd_resp;
                    rdata_d   = rd_data;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            aw_rdy_q     <= 1'b0;
            ar_rdy_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            commit_cnt_q <= '0;
            snap_cnt_q   <= '0;
            strobe_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_rdy_q  <= aw_rdy_d;
            ar_rdy_q  <= ar_rdy_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            strobe_q  <= commit;
            if (commit)   commit_cnt_q <= commit_cnt_q + 16'd1;
            if (snapshot) snap_cnt_q   <= snap_cnt_q + 16'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        motor_ctrl_chan_regs #(
            .KP_RESET (KP_RESET),
            .KI_RESET (KI_RESET)
        ) u_ch (
            .clk_i      (s00_axi_aclk),
            .rst_i      (s00_axi_areset),
            .gain_we_i  (wr_hs & gain_sel[c]),
            .vel_we_i   (wr_hs & vel_sel[c]),
            .commit_i   (commit),
            .snapshot_i (snapshot),
            .wdata_i    (s00_axi_wdata),
            .wstrb_i    (s00_axi_wstrb),
            .pos_i      (actual_pos[32*c +: 32]),
            .vel_i      (actual_vel[32*c +: 32]),
            .gain_sh_o  (gain_sh[c]),
            .vel_sh_o   (vel_sh[c]),
            .pos_snap_o (pos_snap[c]),
            .vel_snap_o (vel_snap[c]),
            .kp_o       (kp_out[16*c +: 16]),
            .ki_o       (ki_out[16*c +: 16]),
            .vel_o      (desired_vel[32*c +: 32])
        );
    end

    assign s00_axi_awready = aw_rdy_q;
    assign s00_axi_wready  = aw_rdy_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = ar_rdy_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign update_strobe   = strobe_q;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_motor_ctrl_regs_axi.sv
// tb_motor_ctrl_regs_axi: scoreboard bench for the motor control
// register bank; responses are queued at issue and checked on return.
module tb_motor_ctrl_regs_axi;

    localparam int          NCH = 2;
    localparam logic [15:0] KPR = 16'h1234;
    localparam logic [15:0] KIR = 16'h0042;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              bvalid, bready, arvalid, arready;
    logic              rvalid, rready;
    logic [16*NCH-1:0] kp_out, ki_out;
    logic [32*NCH-1:0] desired_vel, actual_pos, actual_vel;
    logic              update_strobe;

    int n_checks = 0;
    int n_err    = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    always #5 clk = ~clk;

    motor_ctrl_regs_axi #(
        .NUM_CH   (NCH),
        .KP_RESET (KPR),
        .KI_RESET (KIR)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .kp_out          (kp_out),
        .ki_out          (ki_out),
        .desired_vel     (desired_vel),
        .actual_pos      (actual_pos),
        .actual_vel      (actual_vel),
        .update_strobe   (update_strobe)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er);
        int n;
        bq.push_back(er);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("aw_timeout", 64'(n < 20), 64'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_timeout", 64'(n < 20), 64'd1);
        check($sformatf("bresp@%h", a), 64'(bresp), 64'(bq.pop_front()));
    endtask

    task automatic axi_read(input logic [6:0] a, input logic [31:0] ed,
                            input logic [1:0] er);
        int n;
        logic [33:0] e;
        rq.push_back({er, ed});
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("ar_timeout", 64'(n < 20), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("r_timeout", 64'(n < 20), 64'd1);
        e = rq.pop_front();
        check($sformatf("rdata@%h", a), 64'(rdata), 64'(e[31:0]));
        check($sformatf("rresp@%h", a), 64'(rresp), 64'(e[33:32]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] gain0;

    initial begin
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        actual_pos = '0; actual_vel = '0;
        do_reset();

        check("rst_valids", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
        check("rst_resp", 64'({bresp, rresp, rdata}), 64'd0);
        check("rst_kp", 64'(kp_out), 64'({KPR, KPR}));
        check("rst_ki", 64'(ki_out), 64'({KIR, KIR}));
        check("rst_vel", 64'(desired_vel), 64'd0);
        check("rst_strobe", 64'(update_strobe), 64'd0);

        axi_read(7'h04, 32'h5056_0002, 2'b00);
        axi_read(7'h08, 32'h0, 2'b00);
        gain0 = {KIR, KPR};
        axi_read(7'h10, gain0, 2'b00);

        // setpoint stays in shadow until commit
        axi_write(7'h14, 32'hFFFF_FC18, 4'hF, 2'b00);
        check("vel_pre_commit", 64'(desired_vel[31:0]), 64'd0);
        axi_read(7'h14, 32'hFFFF_FC18, 2'b00);
        check("vel_still_0", 64'(desired_vel[31:0]), 64'd0);

        axi_write(7'h00, 32'h1, 4'hF, 2'b00);
        check("vel_commit", 64'(desired_vel[31:0]), 64'hFFFF_FC18);
        check("strobe_hi", 64'(update_strobe), 64'd1);
        @(negedge clk);
        check("strobe_lo", 64'(update_strobe), 64'd0);
        axi_read(7'h08, 32'h0000_0001, 2'b00);

        // partial strobe leaves Ki bytes alone
        axi_write(7'h10, 32'h0020_0100, 4'b0011, 2'b00);
        gain0 = {gain0[31:16], 16'h0100};
        axi_read(7'h10, gain0, 2'b00);
        check("kp_no_commit", 64'(kp_out[15:0]), 64'(KPR));
        axi_write(7'h00, 32'h1, 4'hF, 2'b00);
        check("kp_commit", 64'(kp_out[15:0]), 64'h0100);
        check("ki_commit", 64'(ki_out[15:0]), 64'(KIR));
        check("kp1_commit", 64'(kp_out[31:16]), 64'(KPR));

        // CTRL without byte 0 strobed does nothing
        axi_write(7'h00, 32'h3, 4'b0010, 2'b00);
        check("no_strobe", 64'(update_strobe), 64'd0);
        axi_read(7'h08, 32'h0000_0002, 2'b00);

        actual_pos = {32'd12345, 32'd777};
        actual_vel = {32'hFFFF_FFFB, 32'd99};
        axi_write(7'h00, 32'h2, 4'hF, 2'b00);
        actual_pos = '0;
        actual_vel = '0;
        axi_read(7'h28, 32'd12345, 2'b00);
        axi_read(7'h18, 32'd777, 2'b00);
        axi_read(7'h2C, 32'hFFFF_FFFB, 2'b00);
        axi_read(7'h1C, 32'd99, 2'b00);
        axi_read(7'h08, 32'h0001_0002, 2'b00);

        axi_write(7'h18, 32'h0, 4'hF, 2'b10);
        axi_read(7'h18, 32'd777, 2'b00);
        axi_write(7'h40, 32'hDEAD_BEEF, 4'hF, 2'b10);
        axi_read(7'h40, 32'h0, 2'b10);
        axi_write(7'h04, 32'h0, 4'hF, 2'b10);
        axi_read(7'h0C, 32'h0, 2'b00);
        axi_read(7'h30, 32'h0, 2'b10);

        axi_write(7'h00, 32'h3, 4'h1, 2'b00);
        check("both_strobe", 64'(update_strobe), 64'd1);
        axi_read(7'h08, 32'h0002_0003, 2'b00);
        axi_read(7'h1C, 32'd0, 2'b00);

        // stalled responses with a second request pending
        @(negedge clk);
        awaddr = 7'h24; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 7'h04; arvalid = 1'b1; rready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_ctl%0d", i),
                  64'({bvalid, awready, wready, rvalid, arready}),
                  64'b10010);
            check($sformatf("stall_dat%0d", i),
                  64'({bresp, rresp, rdata}), 64'h5056_0002);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_kp", 64'(kp_out), 64'({KPR, KPR}));
        check("post_rst_vel", 64'(desired_vel), 64'd0);
        axi_read(7'h24, 32'h0, 2'b00);
        axi_read(7'h08, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
